uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 51 +++++
 rtl/uart_tx_slot.sv | 63 ++++++
 rtl/uart_tx_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART transmit definitions: frame headers, controller handshake codes,
// arbiter FSM encodings and small helpers used by the arbiter and its slots.
package uart_tx_arbiter_pkg;

   localparam int unsigned FRAME_W = 40;

   localparam logic [7:0]  HDR_ADS_DATA_DEF   = 8'hAA;
   localparam logic [7:0]  HDR_MPR_DATA_DEF   = 8'hBB;
   localparam logic [7:0]  HDR_ADS_REG_DEF    = 8'h61;
   localparam logic [7:0]  HDR_MPR_REG_DEF    = 8'h6D;
   localparam logic [15:0] TIMEOUT_CYCLES_DEF = 16'd65535;

   // Level of the controller's READY line when it is idle and able to take a frame.
   localparam logic UART_CTRL_IDLE = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

   typedef enum logic {
      SRC_ADS = 1'b0,
      SRC_MPR = 1'b1
   } tx_src_e;

   function automatic logic hdr_known(
      input logic [7:0] hdr,
      input logic [7:0] hdr_a,
      input logic [7:0] hdr_b,
      input logic [7:0] hdr_c,
      input logic [7:0] hdr_d
   );
      hdr_known = (hdr == hdr_a) || (hdr == hdr_b) || (hdr == hdr_c) || (hdr == hdr_d);
   endfunction

   function automatic logic [7:0] sat_add_drop(
      input logic [7:0] cnt,
      input logic [1:0] inc
   );
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'd0, inc};
      if (sum[8]) begin
         sat_add_drop = 8'hFF;
      end else begin
         sat_add_drop = sum[7:0];
      end
   endfunction

endpackage

// File: rtl/uart_tx_slot.sv
// One-entry holding register for a frame source; frames with an unknown header
// are discarded at capture and reported through a single-cycle drop pulse.
module uart_tx_slot
   import uart_tx_arbiter_pkg::*;
#(
   parameter logic [7:0] HDR_A = HDR_ADS_DATA_DEF,
   parameter logic [7:0] HDR_B = HDR_MPR_DATA_DEF,
   parameter logic [7:0] HDR_C = HDR_ADS_REG_DEF,
   parameter logic [7:0] HDR_D = HDR_MPR_REG_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [FRAME_W-1:0] data_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               free_i,
   output logic               full_o,
   output logic [FRAME_W-1:0] data_o,
   output logic               drop_o
);

   logic               full_q;
   logic               full_d;
   logic [FRAME_W-1:0] data_q;
   logic [FRAME_W-1:0] data_d;
   logic               capture_s;
   logic               hdr_ok_s;

   // Capture/discard on handshake, release when the arbiter frees the entry.
   always_comb begin
      hdr_ok_s  = hdr_known(data_i[FRAME_W-1:FRAME_W-8], HDR_A, HDR_B, HDR_C, HDR_D);
      capture_s = valid_i & ~full_q;
      full_d    = full_q;
      data_d    = data_q;
      if (capture_s && hdr_ok_s) begin
         full_d = 1'b1;
         data_d = data_i;
      end else if (free_i) begin
         full_d = 1'b0;
         data_d = 40'd0;
      end else begin
         full_d = full_q;
         data_d = data_q;
      end
   end

   // Holding register state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= 40'd0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign ready_o = ~full_q;
   assign full_o  = full_q;
   assign data_o  = data_q;
   assign drop_o  = capture_s & ~hdr_ok_s;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates ADS and MPR frames onto a single UART controller transmit port,
// with round-robin on contention, header filtering and a wait-state watchdog.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter logic [7:0]  HDR_ADS_DATA   = HDR_ADS_DATA_DEF,
   parameter logic [7:0]  HDR_MPR_DATA   = HDR_MPR_DATA_DEF,
   parameter logic [7:0]  HDR_ADS_REG    = HDR_ADS_REG_DEF,
   parameter logic [7:0]  HDR_MPR_REG    = HDR_MPR_REG_DEF,
   parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic               i_CLK,
   input  logic               i_RST,
   input  logic [FRAME_W-1:0] i_ADS_DATA_TX,
   input  logic               i_ADS_DATA_TX_VALID,
   output logic               o_ADS_DATA_TX_READY,
   input  logic [FRAME_W-1:0] i_MPR_DATA_TX,
   input  logic               i_MPR_DATA_TX_VALID,
   output logic               o_MPR_DATA_TX_READY,
   output logic [FRAME_W-1:0] o_UART_DATA_TX,
   output logic               o_UART_DATA_TX_VALID,
   input  logic               i_UART_DATA_TX_READY,
   output logic [7:0]         o_DROP_CNT,
   output logic               o_TIMEOUT
);

   tx_state_e          state_q;
   tx_state_e          state_d;
   tx_src_e            grant_q;
   tx_src_e            grant_d;
   tx_src_e            pref_q;
   tx_src_e            pref_d;
   tx_src_e            pick_s;
   logic [15:0]        cnt_q;
   logic [15:0]        cnt_d;
   logic [FRAME_W-1:0] tx_data_q;
   logic [FRAME_W-1:0] tx_data_d;
   logic               tx_valid_q;
   logic               tx_valid_d;
   logic               timeout_q;
   logic               timeout_d;
   logic [7:0]         drop_cnt_q;
   logic [7:0]         drop_cnt_d;

   logic               ads_full_s;
   logic               mpr_full_s;
   logic [FRAME_W-1:0] ads_data_s;
   logic [FRAME_W-1:0] mpr_data_s;
   logic               ads_drop_s;
   logic               mpr_drop_s;
   logic               ads_free_s;
   logic               mpr_free_s;
   logic               release_s;
   logic               both_full_s;
   logic               ctrl_idle_s;
   logic               cnt_expired_s;

   uart_tx_slot #(
      .HDR_A(HDR_ADS_DATA), .HDR_B(HDR_MPR_DATA), .HDR_C(HDR_ADS_REG), .HDR_D(HDR_MPR_REG)
   ) u_ads_slot (
      .clk_i   (i_CLK),
      .rst_i   (i_RST),
      .data_i  (i_ADS_DATA_TX),
      .valid_i (i_ADS_DATA_TX_VALID),
      .ready_o (o_ADS_DATA_TX_READY),
      .free_i  (ads_free_s),
      .full_o  (ads_full_s),
      .data_o  (ads_data_s),
      .drop_o  (ads_drop_s)
   );

   uart_tx_slot #(
      .HDR_A(HDR_ADS_DATA), .HDR_B(HDR_MPR_DATA), .HDR_C(HDR_ADS_REG), .HDR_D(HDR_MPR_REG)
   ) u_mpr_slot (
      .clk_i   (i_CLK),
      .rst_i   (i_RST),
      .data_i  (i_MPR_DATA_TX),
      .valid_i (i_MPR_DATA_TX_VALID),
      .ready_o (o_MPR_DATA_TX_READY),
      .free_i  (mpr_free_s),
      .full_o  (mpr_full_s),
      .data_o  (mpr_data_s),
      .drop_o  (mpr_drop_s)
   );

   // Grant selection; the preference pointer only moves on contended grants.
   always_comb begin
      both_full_s   = ads_full_s & mpr_full_s;
      ctrl_idle_s   = (i_UART_DATA_TX_READY == UART_CTRL_IDLE);
      cnt_expired_s = (cnt_q >= (TIMEOUT_CYCLES - 16'd1));
      if (both_full_s) begin
         pick_s = pref_q;
      end else if (ads_full_s) begin
         pick_s = SRC_ADS;
      end else begin
         pick_s = SRC_MPR;
      end
   end

   // FSM state register.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if ((ads_full_s || mpr_full_s) && ctrl_idle_s) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (!ctrl_idle_s) begin
               state_d = ST_WAIT_BUSY;
            end else if (cnt_expired_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT_BUSY: begin
            state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (ctrl_idle_s || cnt_expired_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: transmit register, grant bookkeeping, watchdog and drop count.
   always_comb begin
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      grant_d    = grant_q;
      pref_d     = pref_q;
      timeout_d  = timeout_q;
      release_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (state_d == ST_ISSUE) begin
               grant_d    = pick_s;
               tx_valid_d = 1'b1;
               tx_data_d  = (pick_s == SRC_ADS) ? ads_data_s : mpr_data_s;
               if (both_full_s) begin
                  pref_d = (pick_s == SRC_ADS) ? SRC_MPR : SRC_ADS;
               end else begin
                  pref_d = pref_q;
               end
            end else begin
               tx_valid_d = 1'b0;
               tx_data_d  = 40'd0;
            end
         end
         ST_ISSUE: begin
            if (state_d != ST_ISSUE) begin
               release_s  = 1'b1;
               tx_valid_d = 1'b0;
               tx_data_d  = 40'd0;
               timeout_d  = timeout_q | (ctrl_idle_s & cnt_expired_s);
            end else begin
               tx_valid_d = 1'b1;
               tx_data_d  = tx_data_q;
            end
         end
         ST_WAIT_BUSY: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 40'd0;
         end
         ST_WAIT_DONE: begin
            if (!ctrl_idle_s && cnt_expired_s) begin
               timeout_d = 1'b1;
            end else begin
               timeout_d = timeout_q;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 40'd0;
         end
      endcase
      if (state_d != state_q) begin
         cnt_d = 16'd0;
      end else if (cnt_q == 16'hFFFF) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
      drop_cnt_d = sat_add_drop(drop_cnt_q, {1'b0, ads_drop_s} + {1'b0, mpr_drop_s});
   end

   // Registered outputs and arbitration bookkeeping.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= 40'd0;
         grant_q    <= SRC_ADS;
         pref_q     <= SRC_ADS;
         cnt_q      <= 16'd0;
         timeout_q  <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         grant_q    <= grant_d;
         pref_q     <= pref_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign ads_free_s           = release_s & (grant_q == SRC_ADS);
   assign mpr_free_s           = release_s & (grant_q == SRC_MPR);
   assign o_UART_DATA_TX       = tx_data_q;
   assign o_UART_DATA_TX_VALID = tx_valid_q;
   assign o_DROP_CNT           = drop_cnt_q;
   assign o_TIMEOUT            = timeout_q;

endmodule
